// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key event receiver: scan codes, event layout and helpers.
package ps2_pkg;

  // Event word layout: {ext, break, code[7:0]}
  localparam int unsigned EvtWidth   = 10;
  localparam int unsigned EvtCodeMsb = 7;
  localparam int unsigned EvtBrkBit  = 8;
  localparam int unsigned EvtExtBit  = 9;

  localparam logic [7:0] ScExt    = 8'hE0;
  localparam logic [7:0] ScPause  = 8'hE1;
  localparam logic [7:0] ScBreak  = 8'hF0;
  localparam logic [7:0] ScBatOk  = 8'hAA;
  localparam logic [7:0] ScAck    = 8'hFA;
  localparam logic [7:0] ScResend = 8'hFE;
  localparam logic [7:0] ScErr00  = 8'h00;
  localparam logic [7:0] ScErrFf  = 8'hFF;
  localparam logic [7:0] ScLShift = 8'h12;
  localparam logic [7:0] ScRShift = 8'h59;
  localparam logic [7:0] ScCtrl   = 8'h14;
  localparam logic [7:0] ScAlt    = 8'h11;
  localparam logic [7:0] ScCaps   = 8'h58;

  // Bytes that follow E1 in the pause sequence and are swallowed.
  localparam int unsigned PauseSkip = 7;

  function automatic logic is_status(input logic [7:0] b);
    return (b == ScBatOk) || (b == ScAck) || (b == ScResend) || (b == ScErr00) || (b == ScErrFf);
  endfunction

endpackage

// File: rtl/ps2_key_event_rx_if.sv
// Key event valid/ready stream between the PS/2 receiver and its consumer.
interface ps2_key_event_rx_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (output evt_valid, output evt_code, output evt_ext, output evt_break,
                  input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_ext, input evt_break,
                  output evt_ready);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the pins, samples on falling ps2c, checks framing
// and parity, and abandons a stalled partial frame after TIMEOUT_CYCLES.
module ps2_frame_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 27000
) (
  input  logic       clock_27mhz,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]      c_sync_q;
  logic [1:0]      d_sync_q;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            sample, din, timeout;

  assign sample  = c_sync_q[2] & ~c_sync_q[1];
  assign din     = d_sync_q[1];
  assign timeout = (bit_cnt_q != 4'd0) && !sample && (tmr_q == TmrW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    tmr_d     = (sample || bit_cnt_q == 4'd0) ? '0 : tmr_q + 1'b1;
    if (sample) begin
      if (bit_cnt_q == 4'd0) begin
        if (!din) bit_cnt_d = 4'd1;
        else      err_d     = 1'b1;
      end else if (bit_cnt_q <= 4'd8) begin
        shift_d   = {din, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == 4'd9) begin
        parity_d  = din;
        bit_cnt_d = 4'd10;
      end else begin
        bit_cnt_d = 4'd0;
        // Odd parity: data plus parity bit must hold an odd number of ones.
        if (din && (^{shift_q, parity_q})) begin
          byte_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (timeout) begin
      bit_cnt_d = 4'd0;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clock_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      c_sync_q  <= '1;
      d_sync_q  <= '1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmr_q     <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      c_sync_q  <= {c_sync_q[1:0], ps2c};
      d_sync_q  <= {d_sync_q[0], ps2d};
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmr_q     <= tmr_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver top: prefix decoder, modifier tracking, status counters and a
// first-word-fall-through event FIFO behind a valid/ready stream.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 27000
) (
  input  logic                      clock_27mhz,
  input  logic                      reset_n,
  input  logic                      ps2c,
  input  logic                      ps2d,
  ps2_key_event_rx_if.master        evt,
  output logic [3:0]                mods,
  output logic                      overflow,
  output logic [7:0]                frame_errs,
  input  logic                      clear_status
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StExt    = 3'd1;
  localparam logic [2:0] StBrk    = 3'd2;
  localparam logic [2:0] StExtBrk = 3'd3;
  localparam logic [2:0] StSkip   = 3'd4;

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clock_27mhz  (clock_27mhz),
    .reset_n      (reset_n),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  // Decoder
  logic [2:0]          state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic [EvtWidth-1:0] ev_q, ev_d;
  logic                ev_valid_q, ev_valid_d;
  logic                bat_clr;

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    ev_d       = ev_q;
    ev_valid_d = 1'b0;
    bat_clr    = 1'b0;
    if (rx_valid) begin
      if (rx_byte == ScBatOk) begin
        state_d = StIdle;
        bat_clr = 1'b1;
      end else if (state_q == StSkip) begin
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) state_d = StIdle;
      end else if (!is_status(rx_byte)) begin
        if (state_q == StIdle && rx_byte == ScExt) begin
          state_d = StExt;
        end else if (state_q == StIdle && rx_byte == ScBreak) begin
          state_d = StBrk;
        end else if (state_q == StExt && rx_byte == ScBreak) begin
          state_d = StExtBrk;
        end else begin
          ev_valid_d          = 1'b1;
          ev_d[EvtCodeMsb:0]  = rx_byte;
          ev_d[EvtExtBit]     = (state_q == StExt) || (state_q == StExtBrk);
          ev_d[EvtBrkBit]     = (state_q == StBrk) || (state_q == StExtBrk);
          if (state_q == StIdle && rx_byte == ScPause) begin
            state_d = StSkip;
            skip_d  = 3'(PauseSkip);
          end else begin
            state_d = StIdle;
          end
        end
      end
    end
  end

  // Modifiers: held[5:0] = {r_alt, l_alt, r_ctrl, l_ctrl, r_shift, l_shift}
  logic [5:0] held_q, held_d;
  logic       caps_q, caps_d;
  logic       caps_held_q, caps_held_d;
  logic       make;

  assign make = ~ev_q[EvtBrkBit];

  always_comb begin
    held_d      = held_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (bat_clr) begin
      held_d      = '0;
      caps_d      = 1'b0;
      caps_held_d = 1'b0;
    end else if (ev_valid_q) begin
      if (!ev_q[EvtExtBit]) begin
        case (ev_q[EvtCodeMsb:0])
          ScLShift: held_d[0] = make;
          ScRShift: held_d[1] = make;
          ScCtrl:   held_d[2] = make;
          ScAlt:    held_d[4] = make;
          ScCaps: begin
            // Typematic repeats of a held caps key must not toggle again.
            if (make && !caps_held_q) caps_d = ~caps_q;
            caps_held_d = make;
          end
          default: ;
        endcase
      end else begin
        case (ev_q[EvtCodeMsb:0])
          ScCtrl:  held_d[3] = make;
          ScAlt:   held_d[5] = make;
          default: ;
        endcase
      end
    end
  end

  assign mods = {caps_q, |held_q[5:4], |held_q[3:2], |held_q[1:0]};

  // Event FIFO
  logic [EvtWidth-1:0] mem_q [FIFO_DEPTH];
  logic [EvtWidth-1:0] head;
  logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                empty, full, pop, push_ok, drop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = ~empty & evt.evt_ready;
  assign push_ok = ev_valid_q & (~full | pop);
  assign drop    = ev_valid_q & full & ~pop;
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clock_27mhz) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= ev_q;
  end

  assign head          = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign evt.evt_valid = ~empty;
  assign evt.evt_code  = head[EvtCodeMsb:0];
  assign evt.evt_ext   = head[EvtExtBit];
  assign evt.evt_break = head[EvtBrkBit];

  // Status
  logic       overflow_q, overflow_d;
  logic [7:0] errs_q, errs_d;

  always_comb begin
    overflow_d = drop ? 1'b1 : (clear_status ? 1'b0 : overflow_q);
    errs_d     = clear_status ? 8'd0 : errs_q;
    if (rx_err && errs_d != 8'hFF) errs_d = errs_d + 8'd1;
  end

  assign overflow   = overflow_q;
  assign frame_errs = errs_q;

  always_ff @(posedge clock_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      skip_q      <= '0;
      ev_q        <= '0;
      ev_valid_q  <= 1'b0;
      held_q      <= '0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      errs_q      <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      ev_q        <= ev_d;
      ev_valid_q  <= ev_valid_d;
      held_q      <= held_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      errs_q      <= errs_d;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: bit-bangs PS/2 frames and checks events and status.
module tb_ps2_key_event_rx;

  logic       clk;
  logic       rst_n;
  logic       ps2c, ps2d;
  logic [3:0] mods;
  logic       overflow;
  logic [7:0] frame_errs;
  logic       clear_status;

  int n_vec = 0;
  int n_err = 0;

  ps2_key_event_rx_if evt_if ();

  ps2_key_event_rx #(
    .FIFO_DEPTH     (16),
    .TIMEOUT_CYCLES (27000)
  ) dut (
    .clock_27mhz  (clk),
    .reset_n      (rst_n),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .evt          (evt_if.master),
    .mods         (mods),
    .overflow     (overflow),
    .frame_errs   (frame_errs),
    .clear_status (clear_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2d = f[i];
      tick(4);
      ps2c = 1'b0;
      tick(8);
      ps2c = 1'b1;
      tick(4);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 11);
    tick(4);
  endtask

  // Sends a frame and samples valid/mods in cycles S+2 and S+3 around the stop-bit sample.
  task automatic send_watch(input logic [7:0] b, output logic v2, output logic v3,
                            output logic [3:0] m2, output logic [3:0] m3);
    send_bits(mk_frame(b, 1'b0), 10);
    @(negedge clk);
    ps2d = 1'b1;
    tick(4);
    ps2c = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    v2 = evt_if.evt_valid;
    m2 = mods;
    @(posedge clk);
    #1;
    v3 = evt_if.evt_valid;
    m3 = mods;
    tick(8);
    ps2c = 1'b1;
    tick(4);
  endtask

  task automatic pop_check(input string tag, input logic [9:0] exp);
    check_eq({tag, "_valid"}, evt_if.evt_valid, 1);
    check_eq(tag, {evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code}, exp);
    evt_if.evt_ready = 1'b1;
    tick(1);
    evt_if.evt_ready = 1'b0;
  endtask

  task automatic drain(input string tag, input int exp_n);
    int k;
    k = 0;
    evt_if.evt_ready = 1'b1;
    while (evt_if.evt_valid && k < 40) begin
      tick(1);
      k++;
    end
    evt_if.evt_ready = 1'b0;
    check_eq(tag, k, exp_n);
  endtask

  logic       v2, v3;
  logic [3:0] m2, m3;
  logic [7:0] ovf_codes [17];

  initial begin
    ovf_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15};
    rst_n            = 1'b0;
    ps2c             = 1'b1;
    ps2d             = 1'b1;
    clear_status     = 1'b0;
    evt_if.evt_ready = 1'b0;
    tick(5);
    check_eq("rst_valid", evt_if.evt_valid, 0);
    check_eq("rst_code", evt_if.evt_code, 0);
    check_eq("rst_mods", mods, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_errs", frame_errs, 0);
    rst_n = 1'b1;
    tick(5);

    // Latency: event appears exactly at S+3
    send_watch(8'h1C, v2, v3, m2, m3);
    check_eq("lat_s2", v2, 0);
    check_eq("lat_s3", v3, 1);
    pop_check("make_1c", 10'h01C);
    check_eq("empty_after_pop", evt_if.evt_valid, 0);

    send_byte(8'hF0); send_byte(8'h1C);
    pop_check("brk_1c", 10'h11C);

    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    pop_check("ext_brk_75", 10'h375);
    check_eq("ext_brk_single", evt_if.evt_valid, 0);
    send_byte(8'h1C);
    pop_check("idle_after_ext", 10'h01C);

    // Shift tracking, mods visible from S+3
    send_watch(8'h12, v2, v3, m2, m3);
    check_eq("shift_s2", m2, 0);
    check_eq("shift_s3", m3, 4'h1);
    send_byte(8'h1C);
    check_eq("shift_hold", mods, 4'h1);
    send_byte(8'hF0); send_byte(8'h12);
    check_eq("shift_rel", mods, 4'h0);
    drain("shift_drain", 3);

    // Caps lock ignores typematic repeats
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h58);
      check_eq("caps_make", mods, 4'h8);
    end
    send_byte(8'hF0); send_byte(8'h58);
    check_eq("caps_rel", mods, 4'h8);
    send_byte(8'h58);
    check_eq("caps_toggle_off", mods, 4'h0);
    send_byte(8'hF0); send_byte(8'h58);
    drain("caps_drain", 6);

    send_byte(8'hE0); send_byte(8'h14);
    check_eq("rctrl", mods, 4'h2);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    check_eq("rctrl_rel", mods, 4'h0);
    send_byte(8'h11);
    check_eq("lalt", mods, 4'h4);
    send_byte(8'hF0); send_byte(8'h11);
    check_eq("lalt_rel", mods, 4'h0);
    drain("ctrl_alt_drain", 4);

    // Parity error then truncated frame timing out
    send_bits(mk_frame(8'h1C, 1'b1), 11);
    tick(4);
    check_eq("par_err", frame_errs, 1);
    check_eq("par_noevt", evt_if.evt_valid, 0);
    send_bits(mk_frame(8'h1C, 1'b0), 4);
    tick(27100);
    check_eq("tmo_err", frame_errs, 2);
    check_eq("tmo_noevt", evt_if.evt_valid, 0);
    send_byte(8'h1C);
    pop_check("after_tmo", 10'h01C);
    @(negedge clk); clear_status = 1'b1;
    @(negedge clk); clear_status = 1'b0;
    check_eq("errs_clr", frame_errs, 0);

    // Overflow
    for (int i = 0; i < 16; i++) send_byte(ovf_codes[i]);
    check_eq("ovf_before", overflow, 0);
    send_byte(ovf_codes[16]);
    check_eq("ovf_set", overflow, 1);
    @(negedge clk); clear_status = 1'b1;
    @(negedge clk); clear_status = 1'b0;
    check_eq("ovf_clr", overflow, 0);
    for (int i = 0; i < 16; i++) pop_check("ovf_order", {2'b00, ovf_codes[i]});
    check_eq("ovf_empty", evt_if.evt_valid, 0);

    // Pause sequence
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    pop_check("pause", 10'h0E1);
    check_eq("pause_single", evt_if.evt_valid, 0);
    check_eq("pause_mods", mods, 0);
    send_byte(8'h1C);
    pop_check("after_pause", 10'h01C);

    // BAT OK mid-break
    send_byte(8'h12);
    pop_check("bat_pre", 10'h012);
    check_eq("bat_pre_mods", mods, 4'h1);
    send_byte(8'hF0); send_byte(8'hAA);
    check_eq("bat_noevt", evt_if.evt_valid, 0);
    check_eq("bat_mods", mods, 4'h0);
    send_byte(8'hFA);
    check_eq("ack_noevt", evt_if.evt_valid, 0);
    send_byte(8'h1C);
    pop_check("after_bat", 10'h01C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_rx.md
# ps2_key_event_rx

Parametrised PS/2 keyboard receiver for the labkit. It turns raw PS/2 clock/data into decoded key events: a scan code, an extended-code flag (E0) and a make/break flag. Events are buffered in a configurable FIFO behind a valid/ready handshake. The block also tracks live modifier state (shift, ctrl, alt, caps lock), recovers from truncated frames with a timeout, and exposes error status. It sits between the PS/2 connector pins and any downstream consumer, such as an ASCII mapper or the UI controller.

## Interface
- FIFO_DEPTH, 16: event FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 27000: idle clock_27mhz cycles mid-frame before the partial frame is discarded (≈1 ms).
- clock_27mhz  in  1  system clock; the only clock.
- reset_n  in  1  reset, asynchronous assert, active low; clears all state.
- ps2c  in  1  PS/2 clock, asynchronous.
- ps2d  in  1  PS/2 data, asynchronous.
- evt_valid  out  1  FIFO head holds an event; reset 0.
- evt_ready  in  1  consumer accepts the head when evt_valid & evt_ready.
- evt_code  out  8  scan code of head event; reset 0.
- evt_ext  out  1  head event was E0-prefixed; reset 0.
- evt_break  out  1  head event is a release (F0-prefixed); reset 0.
- mods  out  4  live {caps_lock, alt, ctrl, shift}; reset 0.
- overflow  out  1  sticky: an event was dropped because the FIFO was full; reset 0.
- frame_errs  out  8  saturating count of bad or timed-out frames; reset 0.
- clear_status  in  1  one-cycle pulse: clears overflow and frame_errs.

## Operation
- **Sync and sampling**
  - ps2c passes through 3 flops; ps2d passes through 2 flops.
  - A sample occurs on a synchronised falling edge of ps2c.
- **Frame checks**
  - Frame = start(0), 8 data bits LSB first, odd parity, stop(1).
  - A good frame yields one byte.
  - Bad start, bad parity or bad stop: byte dropped, frame_errs +1 (saturates at 255).
- **Timeout**
  - Bit counter ≠ 0 and no sample for TIMEOUT_CYCLES: bit counter returns to 0 and frame_errs +1.
- **Decoder FSM states:** IDLE, EXT, BRK, EXT_BRK, SKIP.
  - IDLE + E0 → EXT.
  - IDLE + F0 → BRK.
  - EXT + F0 → EXT_BRK.
  - Any other byte emits an event: ext=1 in EXT/EXT_BRK; break=1 in BRK/EXT_BRK. The FSM returns to IDLE.
  - IDLE + E1 → emit {ext=0, break=0, code=E1}, then enter SKIP.
  - SKIP discards the next 7 bytes, then returns to IDLE.
- **Status bytes**
  - AA, FA, FE, 00 and FF never enqueue.
  - AA also clears mods and forces the FSM to IDLE.
- **Modifiers** (updated on each emitted event, make=set, break=clear)
  - shift = L(12) | R(59).
  - ctrl = L(14) | R(E0 14).
  - alt = L(11) | R(E0 11).
  - caps_lock toggles on a make of 58 only if 58 is not already held, so typematic repeats are ignored. An internal held bit is cleared on the 58 break.
- **FIFO**
  - First-word-fall-through; entries are {ext, break, code}.
  - Push when full: event dropped, overflow set.
  - Push and pop in the same cycle while full: the push is accepted.
  - Pop when empty: ignored.
  - If clear_status and a new overflow occur in the same cycle, overflow stays 1.

## Timing
- Cycle S = sample of the stop bit.
- The byte is registered at S+1.
- The decoder registers the event at S+2 and it is written to the FIFO.
- With the FIFO previously empty, evt_valid=1 at S+3; latency is 3 cycles.
- mods update at S+2, visible from S+3.
- Pop: after evt_valid & evt_ready at cycle T, the next entry (or evt_valid=0) is shown at T+1.
- Full throughput: one pop per cycle.
- reset_n low mid-frame or mid-sequence discards the partial frame, the FSM state, the FIFO contents and the modifiers immediately.

## Structure
- Package ps2_pkg holds:
  - scan-code constants: E0, E1, F0, AA, FA, FE, 12, 59, 14, 11, 58;
  - the event width (10) and the field positions.
- Sub-module ps2_frame_rx contains sync, sampling, bit counter, parity check and timeout. It outputs byte/byte_valid/frame_err.
- The decoder FSM, modifiers and FIFO live in the top level.

## Test plan
- Frame 1C, then evt_ready=1: event {0,0,1C} at S+3; frame F0,1C → {0,1,1C}.
- E0,F0,75 (up-arrow release) → exactly one event {1,1,75}; decoder is in IDLE afterwards.
- Make 12, make 1C, break 12: mods[0] goes 1 then 0; make 58 ×3 repeat, then break 58 → caps_lock toggled once.
- Parity-error frame, then a 4-bit truncated frame idle for 27000 cycles: frame_errs=2, no events, next good frame 1C decodes.
- evt_ready=0, 17 make events with depth 16 → 16 queued, overflow=1; clear_status → 0; then drain order matches.
- E1 pause sequence (8 bytes) → single E1 event; AA mid-BRK → no event, mods=0.
